// File: rtl/uart_tx_serializer.sv
// ============================================================================
// uart_tx_serializer : drains the TX FIFO and serializes 8N1-style UART frames
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_serializer #(
  parameter int SIZE_DATA  = 8,
  parameter int BAUD_DIV   = 434,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_tx_en,
  input  logic                 i_fifo_empty,
  input  logic [SIZE_DATA-1:0] i_fifo_data,
  output logic                 o_fifo_rd_en,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W  = $clog2(SIZE_DATA + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(SIZE_DATA - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  if (BAUD_DIV < 2) begin : g_bad_baud_div
    $fatal(1, "uart_tx_serializer: BAUD_DIV must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $fatal(1, "uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [SIZE_DATA-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 tx_q, tx_d;
  logic                 rd_en_q, rd_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 baud_tick;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    baud_tick = (baud_q == BAUD_LAST);

    case (state_q)
      S_IDLE: begin
        if (i_tx_en && !i_fifo_empty) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // FIFO read data is valid here, one cycle after the strobe
        shift_d  = i_fifo_data;
        parity_d = (^i_fifo_data) ^ (PARITY_ODD != 0);
        baud_d   = '0;
        bit_d    = '0;
        state_d  = S_START;
      end
      S_START: begin
        if (baud_tick) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from next-state values so they land in flops
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
    rd_en_d = (state_d == S_FETCH);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      parity_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rd_en_q  <= rd_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_tx         = tx_q;
  assign o_fifo_rd_en = rd_en_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
// ============================================================================
// tb_uart_tx_serializer : directed self-checking bench for uart_tx_serializer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance: BAUD_DIV=4, no parity, one stop bit, fed by a small FIFO model
  logic       tx_en;
  logic       m_empty;
  logic [7:0] m_data = 8'h00;
  logic       m_rd, m_tx, m_busy, m_done;

  logic [7:0] mem [0:15];
  logic [3:0] wr_ptr = 4'd0;
  logic [3:0] rd_ptr = 4'd0;
  assign m_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (m_rd) begin
      m_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 4'd1;
    end
  end

  uart_tx_serializer #(
    .SIZE_DATA(8), .BAUD_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_en(tx_en), .i_fifo_empty(m_empty),
    .i_fifo_data(m_data), .o_fifo_rd_en(m_rd), .o_tx(m_tx), .o_busy(m_busy),
    .o_done(m_done)
  );

  // Parity instances: even/1 stop and odd/2 stop, both fed constant 0x07
  logic       p_en;
  logic       p_empty;
  logic [7:0] p_data = 8'h07;
  logic       pe_rd, pe_tx, pe_busy, pe_done;
  logic       po_rd, po_tx, po_busy, po_done;

  uart_tx_serializer #(
    .SIZE_DATA(8), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut_pe (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_en(p_en), .i_fifo_empty(p_empty),
    .i_fifo_data(p_data), .o_fifo_rd_en(pe_rd), .o_tx(pe_tx), .o_busy(pe_busy),
    .o_done(pe_done)
  );

  uart_tx_serializer #(
    .SIZE_DATA(8), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
  ) dut_po (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_en(p_en), .i_fifo_empty(p_empty),
    .i_fifo_data(p_data), .o_fifo_rd_en(po_rd), .o_tx(po_tx), .o_busy(po_busy),
    .o_done(po_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 4'd1;
  endtask

  // Waits (bounded) for a read strobe on the main instance; returns cycles waited
  task automatic wait_rd(input string tag, input int max_cyc, output int cyc);
    logic found;
    found = 1'b0;
    cyc   = 0;
    while (!found && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (m_rd) found = 1'b1;
    end
    chk({tag, " rd_seen"}, {31'd0, found}, 32'd1);
  endtask

  // Called at the negedge of the FETCH cycle; checks the whole 40-cycle frame
  task automatic frame_main(input logic [7:0] b, input string tag, input int drop_at);
    logic [9:0] bits;
    logic [3:0] seg;
    int         n, done_cnt, done_pos, rd_cnt;
    logic       busy_ok;
    bits     = {1'b1, b, 1'b0};
    done_cnt = 0;
    done_pos = 0;
    rd_cnt   = 0;
    busy_ok  = 1'b1;
    @(negedge clk);
    chk({tag, " load_tx"}, {31'd0, m_tx}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      seg = 4'h0;
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        n = 4 * k + j + 1;
        if (n == drop_at) tx_en = 1'b0;
        seg[j] = m_tx;
        if (m_done) begin
          done_cnt++;
          done_pos = n;
        end
        if (m_rd) rd_cnt++;
        if (!m_busy) busy_ok = 1'b0;
      end
      chk($sformatf("%s bit%0d", tag, k), {28'd0, seg}, {28'd0, {4{bits[k]}}});
    end
    chk({tag, " done_cnt"}, done_cnt, 32'd1);
    chk({tag, " done_pos"}, done_pos, 32'd40);
    chk({tag, " rd_in_frame"}, rd_cnt, 32'd0);
    chk({tag, " busy_in_frame"}, {31'd0, busy_ok}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int         cyc, rd_cnt, bad_tx, bad_busy;
    logic       pe_line [0:49];
    logic       po_line [0:49];
    logic [7:0] pe_byte, po_byte, po_stop;
    logic [3:0] pe_par, po_par, pe_stop, po_start;
    int         pe_done_pos, po_done_pos, pe_done_cnt, po_done_cnt, p_rd_cnt;

    // Reset state
    rst_n   = 1'b0;
    tx_en   = 1'b0;
    p_en    = 1'b0;
    p_empty = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset tx", {31'd0, m_tx}, 32'd1);
    chk("reset rd", {31'd0, m_rd}, 32'd0);
    chk("reset busy", {31'd0, m_busy}, 32'd0);
    chk("reset done", {31'd0, m_done}, 32'd0);
    chk("reset pe_tx", {31'd0, pe_tx}, 32'd1);
    chk("reset po_tx", {31'd0, po_tx}, 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame 0xA5
    tx_en = 1'b1;
    push(8'hA5);
    wait_rd("a5", 10, cyc);
    chk("a5 latency", cyc, 32'd1);
    frame_main(8'hA5, "a5", 0);
    @(negedge clk);
    chk("a5 idle rd", {31'd0, m_rd}, 32'd0);
    chk("a5 idle busy", {31'd0, m_busy}, 32'd0);

    // Burst of three, reads spaced 43 cycles
    push(8'h11);
    push(8'h22);
    push(8'h33);
    wait_rd("b11", 10, cyc);
    frame_main(8'h11, "b11", 0);
    @(negedge clk);
    chk("b gap1 rd", {31'd0, m_rd}, 32'd0);
    @(negedge clk);
    chk("b spacing1 rd", {31'd0, m_rd}, 32'd1);
    frame_main(8'h22, "b22", 0);
    @(negedge clk);
    chk("b gap2 rd", {31'd0, m_rd}, 32'd0);
    @(negedge clk);
    chk("b spacing2 rd", {31'd0, m_rd}, 32'd1);
    frame_main(8'h33, "b33", 0);
    @(negedge clk);
    chk("b end busy", {31'd0, m_busy}, 32'd0);

    // Empty FIFO with enable held for 200 cycles
    rd_cnt   = 0;
    bad_tx   = 0;
    bad_busy = 0;
    repeat (200) begin
      @(negedge clk);
      if (m_rd) rd_cnt++;
      if (m_tx !== 1'b1) bad_tx++;
      if (m_busy !== 1'b0) bad_busy++;
    end
    chk("empty rd_cnt", rd_cnt, 32'd0);
    chk("empty tx_low_cycles", bad_tx, 32'd0);
    chk("empty busy_cycles", bad_busy, 32'd0);

    // Parity: 0x07 has three ones -> even parity bit 1, odd parity bit 0
    p_en    = 1'b1;
    p_empty = 1'b0;
    @(negedge clk);
    chk("par pe_rd", {31'd0, pe_rd}, 32'd1);
    chk("par po_rd", {31'd0, po_rd}, 32'd1);
    p_empty     = 1'b1;
    pe_done_pos = 0;
    po_done_pos = 0;
    pe_done_cnt = 0;
    po_done_cnt = 0;
    p_rd_cnt    = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      pe_line[n] = pe_tx;
      po_line[n] = po_tx;
      if (pe_done) begin pe_done_cnt++; pe_done_pos = n; end
      if (po_done) begin po_done_cnt++; po_done_pos = n; end
      if (pe_rd || po_rd) p_rd_cnt++;
    end
    for (int i = 0; i < 8; i++) begin
      pe_byte[i] = pe_line[5 + 4 * i + 1];
      po_byte[i] = po_line[5 + 4 * i + 1];
      po_stop[i] = po_line[41 + i];
    end
    for (int i = 0; i < 4; i++) begin
      pe_par[i]   = pe_line[37 + i];
      po_par[i]   = po_line[37 + i];
      pe_stop[i]  = pe_line[41 + i];
      po_start[i] = po_line[1 + i];
    end
    chk("par pe_data", {24'd0, pe_byte}, 32'h07);
    chk("par po_data", {24'd0, po_byte}, 32'h07);
    chk("par po_start", {28'd0, po_start}, 32'h0);
    chk("par even_bit", {28'd0, pe_par}, 32'hF);
    chk("par odd_bit", {28'd0, po_par}, 32'h0);
    chk("par pe_stop", {28'd0, pe_stop}, 32'hF);
    chk("par po_stop2", {24'd0, po_stop}, 32'hFF);
    chk("par pe_done_pos", pe_done_pos, 32'd44);
    chk("par po_done_pos", po_done_pos, 32'd48);
    chk("par pe_done_cnt", pe_done_cnt, 32'd1);
    chk("par po_done_cnt", po_done_cnt, 32'd1);
    chk("par extra_rd", p_rd_cnt, 32'd0);
    p_en = 1'b0;

    // Disable mid-frame: 0x3C completes, queued bytes wait for re-enable
    push(8'h3C);
    push(8'h44);
    push(8'h55);
    wait_rd("d3c", 10, cyc);
    frame_main(8'h3C, "d3c", 20);
    rd_cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (m_rd) rd_cnt++;
    end
    chk("dis rd_cnt", rd_cnt, 32'd0);
    chk("dis busy", {31'd0, m_busy}, 32'd0);
    chk("dis queued", {28'd0, wr_ptr - rd_ptr}, 32'd2);
    tx_en = 1'b1;
    wait_rd("d44", 10, cyc);
    chk("reen latency", cyc, 32'd1);
    frame_main(8'h44, "d44", 0);
    @(negedge clk);
    @(negedge clk);
    chk("reen spacing rd", {31'd0, m_rd}, 32'd1);
    frame_main(8'h55, "d55", 0);

    // Reset during data bit 3 of 0x66 (bit value 0)
    push(8'h66);
    push(8'h77);
    wait_rd("r66", 10, cyc);
    @(negedge clk);
    repeat (19) @(negedge clk);
    chk("rst pre tx", {31'd0, m_tx}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst async tx", {31'd0, m_tx}, 32'd1);
    chk("rst rd", {31'd0, m_rd}, 32'd0);
    chk("rst busy", {31'd0, m_busy}, 32'd0);
    chk("rst done", {31'd0, m_done}, 32'd0);
    rd_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_rd) rd_cnt++;
    end
    chk("rst hold rd_cnt", rd_cnt, 32'd0);
    rst_n = 1'b1;
    wait_rd("r77", 10, cyc);
    chk("rst resume latency", cyc, 32'd1);
    frame_main(8'h77, "r77", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
